// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 registers the operands with per-group propagate/generate. Stage 2
// resolves the group carries, then the in-group carries, sum and flags.
// Valid/ready handshake on both sides; in_ready is combinational from out_ready.
// Optional feature: define CLA_SAT_EN to add the Sat input (signed saturation).
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
`ifdef CLA_SAT_EN
  input  logic             Sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OV,
  output logic             Z
);

  localparam int NG = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and at least 4");
  end
  if (GROUP != 4) begin : g_bad_group
    $error("pipelined_cla_adder: GROUP must be 4");
  end

  // Stage 1 operand preparation
  logic [WIDTH-1:0] w_b_eff, w_p, w_g;
  logic             w_c_eff;
  logic [NG-1:0]    w_gp, w_gg;
  logic             w_adv, w_accept;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic             r_s1_c, r_s1_a_msb, r_s1_b_msb;
  logic [NG-1:0]    r_s1_gp, r_s1_gg;
`ifdef CLA_SAT_EN
  logic             r_s1_sat;
`endif

  // Stage 2 combinational
  logic [WIDTH-1:0] w_s2_p, w_s2_g, w_bc, w_sum, w_res;
  logic [NG:0]      w_gc;
  logic             w_ov;

  // Output registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_co, r_ov, r_z;

  assign w_b_eff  = Sub ? ~B : B;
  assign w_c_eff  = Sub ? ~Cin : Cin;
  assign w_p      = A ^ w_b_eff;
  assign w_g      = A & w_b_eff;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_adv;
  assign w_accept = in_valid && in_ready;

  // Per-group propagate (AND of bit propagates) and group generate
  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  // Stage 1: capture a beat on accept, empty when drained into the output stage
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= 1'b0;
      r_s1_a_msb <= 1'b0;
      r_s1_b_msb <= 1'b0;
      r_s1_gp    <= '0;
      r_s1_gg    <= '0;
`ifdef CLA_SAT_EN
      r_s1_sat   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= A;
      r_s1_b     <= w_b_eff;
      r_s1_c     <= w_c_eff;
      r_s1_a_msb <= A[WIDTH-1];
      r_s1_b_msb <= w_b_eff[WIDTH-1];
      r_s1_gp    <= w_gp;
      r_s1_gg    <= w_gg;
`ifdef CLA_SAT_EN
      r_s1_sat   <= Sat;
`endif
    end else if (w_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  assign w_s2_p = r_s1_a ^ r_s1_b;
  assign w_s2_g = r_s1_a & r_s1_b;

  // Group carries from the registered group propagate/generate
  always_comb begin
    w_gc    = '0;
    w_gc[0] = r_s1_c;
    for (int unsigned k = 0; k < NG; k++) begin
      w_gc[k+1] = r_s1_gg[k] | (r_s1_gp[k] & w_gc[k]);
    end
  end

  // In-group bit carries with the 4-bit lookahead equations
  always_comb begin
    w_bc = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_bc[4*k]   = w_gc[k];
      w_bc[4*k+1] = w_s2_g[4*k] | (w_s2_p[4*k] & w_gc[k]);
      w_bc[4*k+2] = w_s2_g[4*k+1]
                  | (w_s2_p[4*k+1] & w_s2_g[4*k])
                  | (w_s2_p[4*k+1] & w_s2_p[4*k] & w_gc[k]);
      w_bc[4*k+3] = w_s2_g[4*k+2]
                  | (w_s2_p[4*k+2] & w_s2_g[4*k+1])
                  | (w_s2_p[4*k+2] & w_s2_p[4*k+1] & w_s2_g[4*k])
                  | (w_s2_p[4*k+2] & w_s2_p[4*k+1] & w_s2_p[4*k] & w_gc[k]);
    end
  end

  assign w_sum = w_s2_p ^ w_bc;
  assign w_ov  = (r_s1_a_msb == r_s1_b_msb) && (w_sum[WIDTH-1] != r_s1_a_msb);

`ifdef CLA_SAT_EN
  // Positive overflow only happens with A non-negative, so A's sign picks the rail
  assign w_res = (r_s1_sat && w_ov) ? {r_s1_a_msb, {(WIDTH-1){~r_s1_a_msb}}} : w_sum;
`else
  assign w_res = w_sum;
`endif

  // Output stage: load from stage 1 when empty or being consumed, else hold
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_co        <= 1'b0;
      r_ov        <= 1'b0;
      r_z         <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum <= w_res;
        r_co  <= w_gc[NG];
        r_ov  <= w_ov;
        r_z   <= (w_res == '0);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign Sum       = r_sum;
  assign CO        = r_co;
  assign OV        = r_ov;
  assign Z         = r_z;

endmodule
